arm_multicycle_ctrl: RTL
========================

# arm_multicycle_ctrl

Multicycle control unit for the ARM_Calculator core. It sequences the shared datapath (one memory port, one ALU, one register file) through fetch, decode and execute steps, holds the NZCV flags, and evaluates the condition field. It generates every datapath strobe and mux select, including PC-write qualification: PCS = ((rd == 4'b1111) & reg-write) | branch, gated by the condition check.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cond  in  4  instruction bits [31:28]
- op  in  2  instruction bits [27:26]
- funct  in  6  instruction bits [25:20]: I, cmd[3:0], S/L
- rd  in  4  instruction bits [15:12]
- alu_flags  in  4  ALU result flags {N,Z,C,V}, same cycle
- mem_ready  in  1  memory done (used only with MCTRL_MEM_WAIT_EN)
- pc_write, ir_write, reg_write, mem_write  out  1 each  write strobes
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- alu_src_a  out  1  ALU A select: 0 = register A, 1 = PC
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = ExtImm, 10 = constant 4
- alu_control  out  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 ORR
- result_src  out  2  result select: 00 ALUOut, 01 read data, 10 ALU direct
- state  out  4  current state, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op=01→MEMADR; op=00 with funct[5]=0→EXECR; op=00 with funct[5]=1→EXECI; op=10→BRANCH; op=11→FETCH (no side effects).
  - MEMADR: funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
- cond_ex register: loaded at the end of DECODE from cond and the current flags.
  - Decoding: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 → 0.
- Moore outputs per state; unlisted outputs are 0:
  - FETCH: ir_write=1, pc_write=1, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - DECODE: alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - MEMADR: alu_src_b=01, ADD.
  - MEMRD: adr_src=1.
  - MEMWB: result_src=01, reg_write=cond_ex, pc_write=cond_ex&(rd==15).
  - MEMWR: adr_src=1, mem_write=cond_ex.
  - EXECR: alu_src_b=00, decoded ALU op. EXECI: alu_src_b=01, decoded ALU op.
  - ALUWB: reg_write=cond_ex, pc_write=cond_ex&(rd==15).
  - BRANCH: alu_src_b=01, ADD, result_src=10, pc_write=cond_ex.
- ALU decode of cmd=funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other value → ADD.
- Flag update: at the end of EXECR/EXECI, only when funct[0]=1 and cond_ex=1.
  - ADD/SUB: N,Z,C,V all loaded from alu_flags.
  - AND/ORR: N,Z loaded; C,V keep their value.

## Timing
- Reset (rst_n=0, asynchronous): state=FETCH, flags=0000, cond_ex=0. All write strobes (pc_write, ir_write, reg_write, mem_write) are forced to 0 while rst_n is low. The first FETCH strobes appear in the first cycle after rst_n deasserts.
- Instruction latency in cycles: load 5, store 4, data-processing 4, branch 3, op=11 2.
- Write strobes are single-cycle per state visit. Datapath registers capture on the same rising edge that ends the state.
- Asserting reset mid-instruction aborts it immediately. No partial flag update is allowed.
- Flag write and cond_ex load never coincide: they occur in different states.

## Configuration
- MCTRL_MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold until mem_ready=1.
  - In FETCH, ir_write and pc_write assert only in the cycle where mem_ready=1.
  - mem_write stays high for the whole of MEMWR.
  - Each instruction's latency grows by the number of wait cycles.
- Undefined: mem_ready is ignored and every state lasts exactly one cycle.

## Test plan
- Reset, then ADD R1,R2,R3 (cond=1110, op=00, funct=001000, rd=1): state sequence 0,1,6,8,0; reg_write=1 only in state 8; alu_control=00.
- SUBS R0,R0,R0 with alu_flags=0100, then BEQ (cond=0000, op=10): flags become 0100; BRANCH asserts pc_write=1. The same BNE → pc_write=0, and the FSM still returns to FETCH.
- LDR PC,[R1] (op=01, funct[0]=1, rd=15): state sequence 0,1,2,3,4,0; MEMWB asserts reg_write=1, pc_write=1, result_src=01.
- STR with cond=0001 while Z=1: MEMWR with mem_write=0, 4 cycles total.
- ORRS with alu_flags=1011, previous flags 0011: new flags 1011 in N,Z; C,V unchanged at 11. Reset pulsed during ALUWB: state=0 and strobes=0 asynchronously.
- With MCTRL_MEM_WAIT_EN and mem_ready low for 3 cycles in FETCH: state holds at 0 and ir_write stays 0 until mem_ready rises; then exactly one ir_write pulse.

Source files
------------

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle FSM, NZCV flags and condition check for the ARM_Calculator datapath.
// Optional MCTRL_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module arm_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_control,
    output logic [1:0] result_src,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;
    state_t st, nxt;
    logic [3:0] flags;
    logic cond_ex, cond_ok, ready, pcw, irw, rgw, mw;
    logic [1:0] alu_dec;
`ifdef MCTRL_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flags[2];
            4'b0001: cond_ok = !flags[2];
            4'b0010: cond_ok = flags[1];
            4'b0011: cond_ok = !flags[1];
            4'b0100: cond_ok = flags[3];
            4'b0101: cond_ok = !flags[3];
            4'b0110: cond_ok = flags[0];
            4'b0111: cond_ok = !flags[0];
            4'b1000: cond_ok = flags[1] && !flags[2];
            4'b1001: cond_ok = !flags[1] || flags[2];
            4'b1010: cond_ok = flags[3] == flags[0];
            4'b1011: cond_ok = flags[3] != flags[0];
            4'b1100: cond_ok = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_ok = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end
    always_comb
        alu_dec = funct[4:1] == 4'b0010 ? 2'b01 :
                  funct[4:1] == 4'b0000 ? 2'b10 :
                  funct[4:1] == 4'b1100 ? 2'b11 : 2'b00;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= FETCH;
            flags   <= 4'b0000;
            cond_ex <= 1'b0;
        end else begin
            st <= nxt;
            if (st == DECODE)
                cond_ex <= cond_ok;
            // logical ops leave C and V untouched
            if ((st == EXECR || st == EXECI) && funct[0] && cond_ex)
                flags <= alu_dec[1] ? {alu_flags[3:2], flags[1:0]} : alu_flags;
        end
    end
    always_comb begin
        nxt         = FETCH;
        pcw         = 1'b0;
        irw         = 1'b0;
        rgw         = 1'b0;
        mw          = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 2'b00;
        result_src  = 2'b00;
        case (st)
            FETCH: begin
                nxt        = ready ? DECODE : FETCH;
                irw        = ready;
                pcw        = ready;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                nxt        = op == 2'b01 ? MEMADR :
                             op == 2'b00 ? (funct[5] ? EXECI : EXECR) :
                             op == 2'b10 ? BRANCH : FETCH;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            MEMADR: begin
                nxt       = funct[0] ? MEMRD : MEMWR;
                alu_src_b = 2'b01;
            end
            MEMRD: begin
                nxt     = ready ? MEMWB : MEMRD;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                rgw        = cond_ex;
                pcw        = cond_ex && rd == 4'b1111;
            end
            MEMWR: begin
                nxt     = ready ? FETCH : MEMWR;
                adr_src = 1'b1;
                mw      = cond_ex;
            end
            EXECR: begin
                nxt         = ALUWB;
                alu_control = alu_dec;
            end
            EXECI: begin
                nxt         = ALUWB;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
            end
            ALUWB: begin
                rgw = cond_ex;
                pcw = cond_ex && rd == 4'b1111;
            end
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pcw        = cond_ex;
            end
            default: nxt = FETCH;
        endcase
    end
    assign pc_write  = pcw && rst_n;
    assign ir_write  = irw && rst_n;
    assign reg_write = rgw && rst_n;
    assign mem_write = mw && rst_n;
    assign state     = st;
endmodule
